mux_memoria_rr: RTL and testbench
=================================

# mux_memoria_rr

Parametrised N-channel multiplexer with registered, holding output ("mux with memory"), generalising the 2-to-1 2-bit mux with memory. It supports a fixed-selector mode and a round-robin mode gated by per-channel valids. A saturating counter tracks 0→1 bit transitions on the output. It sits between the channel sources and the single downstream consumer, and is the DUT for the conductual-vs-estructural (Yosys) comparison bench.

## Interface
- WIDTH, 2, data width per channel
- CHANNELS, 4, number of input channels (≥2, need not be a power of two)
- CNT_W, 4, width of the rise counter
- SEL_W, $clog2(CHANNELS), derived; selector/channel index width

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- reset_L  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- selector  input  SEL_W  channel index used in mode 0
- valid_in  input  CHANNELS  per-channel data valid
- data_in  input  CHANNELS*WIDTH  packed; channel i occupies bits [i*WIDTH +: WIDTH]
- count_clr  input  1  synchronous clear of rise_count
- data_out  output  WIDTH  registered selected data; holds when nothing is captured
- valid_out  output  1  registered; 1 for exactly the cycle after a capture
- channel_out  output  SEL_W  registered index of the captured channel
- grant  output  CHANNELS  registered one-hot of the captured channel; 0 when valid_out=0
- rise_count  output  CNT_W  saturating count of output bits rising 0→1

## Operation
- Reset (reset_L=0, asynchronous): data_out=0, valid_out=0, channel_out=0, grant=0, rise_count=0. Internal RR pointer = CHANNELS-1, so the first RR search starts at channel 0. Reset asserted mid-operation aborts everything immediately; there is no pending state.
- Mode 0 (fixed):
  - If selector<CHANNELS and valid_in[selector]=1: capture data_in[selector]; valid_out=1; channel_out=selector; grant=1<<selector.
  - Otherwise: valid_out=0, grant=0, data_out and channel_out hold.
  - An out-of-range selector never captures.
- Mode 1 (round-robin):
  - Search channels ptr+1, ptr+2, … cyclically (mod CHANNELS) and take the first with valid_in=1.
  - Capture it as in mode 0, then set ptr to the granted index.
  - If no valid_in is set: no capture, and ptr, data_out and channel_out hold.
- The RR pointer is kept in mode 0 and is not modified by mode-0 captures.
- mode and selector are sampled at each edge, so a mode change takes effect on the same edge it is sampled.
- rise_count:
  - On each edge, add popcount(~data_out_q & data_out_d), where data_out_d is the next value. This is zero when no capture occurs.
  - Saturates at 2^CNT_W-1 and never wraps.
  - count_clr=1 forces 0 and has priority over a simultaneous increment.
  - Example: 00→11 adds 2; 01→10 adds 1.

## Timing
- Latency: data_in/valid_in sampled at edge k appear on data_out/valid_out/grant after edge k (one cycle).
- No backpressure: the consumer must take data_out while valid_out=1. A full-rate stream is accepted every cycle.
- rise_count updates on the same edge as data_out.
- RR fairness: with all channels continuously valid, the grant sequence is 0,1,…,CHANNELS-1,0,…, one channel per cycle.

## Structure
- Shared package mux_memoria_pkg holds:
  - constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a popcount function parametrised by width;
  - a saturating-add helper.
- One sub-module, rr_arbiter: inputs req[CHANNELS] and ptr; outputs one-hot gnt, index and any_gnt; purely combinational.
  - The top instantiates it and owns the pointer, data, count and output registers.
- Everything must stay synthesizable by Yosys with no initial blocks or delays.

## Test plan
All scenarios use WIDTH=2, CHANNELS=4, CNT_W=4.
- Reset: drive inputs non-zero, pulse reset_L low between edges -> all outputs 0 immediately, before the next edge; after release with mode=1 and valid_in=4'b1111, the first grant is 4'b0001.
- Mode 0: selector=2, valid_in=4'b0100, data_in channel 2 = 2'b11 -> next cycle data_out=11, valid_out=1, channel_out=2, rise_count=2. Then valid_in=0 -> valid_out=0, data_out stays 11.
- Mode 1 full rate: valid_in=4'b1111 for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Mode 1 sparse: valid_in=4'b1010 constant -> grants alternate 1,3,1,3. Then valid_in=0 -> valid_out=0, and after restoring 4'b1010 the next grant continues from the pointer.
- Counter: alternate captures 00,11 repeatedly -> rise_count 2,4,…,14, then saturates at 15. count_clr asserted on the same edge as a rise -> rise_count=0.
- Conductual vs estructural: random mode/selector/valid_in/data_in for 200 cycles -> the Yosys netlist matches the behavioural model on every output each cycle.

Source files
------------

// File: rtl/mux_memoria_pkg.sv
// Shared constants and helpers for the mux_memoria_rr block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: mode encodings, width-bounded popcount, saturating add.
package mux_memoria_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest vector the helpers accept; callers zero-extend into it.
  localparam int POP_MAX_W = 32;

  // Counts set bits among the low 'w' bits of v.
  function automatic int popcount(input logic [POP_MAX_W-1:0] v, input int w);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < w && v[i]) n++;
    end
    return n;
  endfunction

  // a + b clamped to max; the 33-bit sum cannot overflow.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) return max;
    return s[31:0];
  endfunction

endpackage

// File: rtl/mux_memoria_rr_if.sv
// Bundles the channel inputs and registered outputs of mux_memoria_rr.
// Latency: n/a (wires only).
// Backpressure: none; master = source/consumer side, slave = the mux.
interface mux_memoria_rr_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      mode;
  logic [SEL_W-1:0]          selector;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      count_clr;
  logic [WIDTH-1:0]          data_out;
  logic                      valid_out;
  logic [SEL_W-1:0]          channel_out;
  logic [CHANNELS-1:0]       grant;
  logic [CNT_W-1:0]          rise_count;

  modport master (
    output mode, selector, valid_in, data_in, count_clr,
    input  data_out, valid_out, channel_out, grant, rise_count
  );

  modport slave (
    input  mode, selector, valid_in, data_in, count_clr,
    output data_out, valid_out, channel_out, grant, rise_count
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after ptr_i, searching cyclically.
// Latency: 0 (purely combinational).
// Backpressure: none.
// Ports: req_i requests, ptr_i last granted index; gnt_o one-hot, idx_o index,
//        any_gnt_o set when some request was found.
module rr_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]                                req_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ptr_i,
  output logic [CHANNELS-1:0]                                gnt_o,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] idx_o,
  output logic                                               any_gnt_o
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  always_comb begin
    int  c;
    logic found;
    c         = 0;
    found     = 1'b0;
    gnt_o     = '0;
    idx_o     = '0;
    // Offsets 1..CHANNELS put ptr_i itself last, so the previous winner
    // only wins again when nobody else is asking.
    for (int k = 1; k <= CHANNELS; k++) begin
      c = (int'(ptr_i) + k) % CHANNELS;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = SEL_W'(c);
      end
    end
    any_gnt_o = found;
  end

endmodule

// File: rtl/mux_memoria_rr.sv
// N-channel mux with registered, holding output; fixed-select or round-robin.
// Latency: 1 cycle from valid_in/data_in to data_out/valid_out/grant.
// Backpressure: none; a capture may occur every cycle and must be consumed.
// Ports: clk, reset_L (async, active-low); bus = slave side of mux_memoria_rr_if
//        (mode, selector, valid_in, data_in, count_clr in; data_out, valid_out,
//        channel_out, grant, rise_count out).
module mux_memoria_rr
  import mux_memoria_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  mux_memoria_rr_if.slave    bus
);
  localparam int          SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic [CHANNELS-1:0] arb_gnt;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;

  logic                cap;
  logic [SEL_W-1:0]    cap_idx;
  logic [WIDTH-1:0]    cap_data;
  logic [WIDTH-1:0]    rise_bits;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req_i     (bus.valid_in),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .any_gnt_o (arb_any)
  );

  // Choose which channel (if any) is captured this edge.
  always_comb begin
    cap     = 1'b0;
    cap_idx = '0;
    if (bus.mode == MODE_FIXED) begin
      // Compare against every legal index so an out-of-range selector
      // simply matches nothing.
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.selector == SEL_W'(i) && bus.valid_in[i]) begin
          cap     = 1'b1;
          cap_idx = SEL_W'(i);
        end
      end
    end else if (arb_any) begin
      cap     = 1'b1;
      cap_idx = arb_idx;
    end
  end

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cap_idx == SEL_W'(i)) cap_data = bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    grant_d = '0;
    if (cap) begin
      data_d  = cap_data;
      chan_d  = cap_idx;
      valid_d = 1'b1;
      grant_d = CHANNELS'(1) << cap_idx;
      // Fixed-mode captures leave the RR history untouched.
      if (bus.mode == MODE_RR) ptr_d = cap_idx;
    end
  end

  // Rising bits are zero whenever data_d holds, so no capture gating needed.
  assign rise_bits = ~data_q & data_d;

  always_comb begin
    cnt_d = CNT_W'(sat_add(32'(cnt_q), 32'(popcount(POP_MAX_W'(rise_bits), WIDTH)), CNT_MAX));
    if (bus.count_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.channel_out = chan_q;
  assign bus.grant       = grant_q;
  assign bus.rise_count  = cnt_q;

endmodule

// File: tb/tb_mux_memoria_rr.sv
// Self-checking bench for mux_memoria_rr (WIDTH=2, CHANNELS=4, CNT_W=4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none exercised; the bench is the always-ready consumer.
module tb_mux_memoria_rr;
  localparam int WIDTH    = 2;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic reset_L;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state kept as plain integers.
  int m_data, m_valid, m_ch, m_grant, m_cnt, m_ptr;

  always #5 clk = ~clk;

  mux_memoria_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

  mux_memoria_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  typedef struct {
    logic       m;
    int         s;
    logic [3:0] v;
    logic [7:0] d;
    logic       c;
    int         e_data;
    int         e_valid;
    int         e_ch;
    int         e_grant;
    int         e_cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 0; m_valid = 0; m_ch = 0; m_grant = 0; m_cnt = 0; m_ptr = CHANNELS - 1;
  endtask

  // Behavioural rules: pick a channel, capture it, count new 1 bits.
  task automatic model_update(input logic m, input int s, input logic [3:0] v,
                              input logic [7:0] d, input logic c);
    int pick, nd, rises;
    pick  = -1;
    rises = 0;
    if (m == 1'b0) begin
      if (s < CHANNELS && v[s]) pick = s;
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        if (pick < 0 && v[(m_ptr + k) % CHANNELS]) pick = (m_ptr + k) % CHANNELS;
      end
    end
    if (pick >= 0) begin
      nd      = (int'(d) >> (WIDTH * pick)) & 3;
      rises   = $countones((~m_data) & nd & 3);
      m_data  = nd;
      m_ch    = pick;
      m_valid = 1;
      m_grant = 1 << pick;
      if (m == 1'b1) m_ptr = pick;
    end else begin
      m_valid = 0;
      m_grant = 0;
    end
    if (c) m_cnt = 0;
    else   m_cnt = (m_cnt + rises > 15) ? 15 : m_cnt + rises;
  endtask

  task automatic step(input logic m, input int s, input logic [3:0] v,
                      input logic [7:0] d, input logic c);
    bus.mode      = m;
    bus.selector  = 2'(s);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.count_clr = c;
    @(posedge clk);
    #1;
    model_update(m, s, v, d, c);
    check("model_data",  int'(bus.data_out),    m_data);
    check("model_valid", int'(bus.valid_out),   m_valid);
    check("model_ch",    int'(bus.channel_out), m_ch);
    check("model_grant", int'(bus.grant),       m_grant);
    check("model_cnt",   int'(bus.rise_count),  m_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  int'(bus.data_out),    0);
    check({tag, "_valid"}, int'(bus.valid_out),   0);
    check({tag, "_ch"},    int'(bus.channel_out), 0);
    check({tag, "_grant"}, int'(bus.grant),       0);
    check({tag, "_cnt"},   int'(bus.rise_count),  0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_L       = 1'b1;
    bus.mode      = 1'b1;
    bus.selector  = 2'd3;
    bus.valid_in  = 4'hF;
    bus.data_in   = 8'hFF;
    bus.count_clr = 1'b0;
    #1;
    reset_L = 1'b0;
    #1;
    check_zero("por");
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();

    // Full-rate round robin from reset: grants 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 0, 4'hF, 8'hE4, 1'b0);
      check("fullrate_grant", int'(bus.grant), 1 << (k % 4));
      check("fullrate_data",  int'(bus.data_out), k % 4);
    end

    // Async reset with live, non-zero outputs, then first RR grant is channel 0.
    step(1'b1, 0, 4'hF, 8'hFF, 1'b0);
    do_reset("async");
    step(1'b1, 0, 4'hF, 8'hE4, 1'b0);
    check("first_grant", int'(bus.grant), 1);

    do_reset("rst2");
    //         m    s  v      d      c     data v ch grant cnt
    tbl[0]  = '{1'b0, 2, 4'h4, 8'h30, 1'b0, 3, 1, 2, 4, 2};
    tbl[1]  = '{1'b0, 2, 4'h0, 8'h30, 1'b0, 3, 0, 2, 0, 2};
    tbl[2]  = '{1'b0, 1, 4'h2, 8'h04, 1'b0, 1, 1, 1, 2, 2};
    tbl[3]  = '{1'b1, 0, 4'hF, 8'hE4, 1'b0, 0, 1, 0, 1, 2};
    tbl[4]  = '{1'b1, 0, 4'hF, 8'hE4, 1'b0, 1, 1, 1, 2, 3};
    tbl[5]  = '{1'b1, 0, 4'hF, 8'hE4, 1'b0, 2, 1, 2, 4, 4};
    tbl[6]  = '{1'b1, 0, 4'hF, 8'hE4, 1'b0, 3, 1, 3, 8, 5};
    tbl[7]  = '{1'b1, 0, 4'hF, 8'hE4, 1'b0, 0, 1, 0, 1, 5};
    tbl[8]  = '{1'b1, 0, 4'hA, 8'hE4, 1'b0, 1, 1, 1, 2, 6};
    tbl[9]  = '{1'b1, 0, 4'hA, 8'hE4, 1'b0, 3, 1, 3, 8, 7};
    tbl[10] = '{1'b1, 0, 4'hA, 8'hE4, 1'b0, 1, 1, 1, 2, 7};
    tbl[11] = '{1'b1, 0, 4'h0, 8'hE4, 1'b0, 1, 0, 1, 0, 7};
    tbl[12] = '{1'b1, 0, 4'hA, 8'hE4, 1'b0, 3, 1, 3, 8, 8};
    tbl[13] = '{1'b0, 0, 4'h1, 8'hE4, 1'b1, 0, 1, 0, 1, 0};
    tbl[14] = '{1'b0, 3, 4'h8, 8'hE4, 1'b1, 3, 1, 3, 8, 0};
    tbl[15] = '{1'b1, 0, 4'hF, 8'hE4, 1'b0, 0, 1, 0, 1, 0};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("tbl%0d_data", i),  int'(bus.data_out),    tbl[i].e_data);
      check($sformatf("tbl%0d_valid", i), int'(bus.valid_out),   tbl[i].e_valid);
      check($sformatf("tbl%0d_ch", i),    int'(bus.channel_out), tbl[i].e_ch);
      check($sformatf("tbl%0d_grant", i), int'(bus.grant),       tbl[i].e_grant);
      check($sformatf("tbl%0d_cnt", i),   int'(bus.rise_count),  tbl[i].e_cnt);
    end

    // Counter: alternate 00 / 11 captures; +2 per rise, clamps at 15.
    step(1'b0, 0, 4'h1, 8'h00, 1'b1);
    check("sat_clear", int'(bus.rise_count), 0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 0, 4'h1, 8'hFF, 1'b0);
      check($sformatf("sat_rise%0d", k), int'(bus.rise_count), (2 * k > 15) ? 15 : 2 * k);
      step(1'b0, 0, 4'h1, 8'h00, 1'b0);
      check($sformatf("sat_hold%0d", k), int'(bus.rise_count), (2 * k > 15) ? 15 : 2 * k);
    end

    // Random mixed traffic against the reference.
    for (int k = 0; k < 200; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
